// File: rtl/acf_accumulator_if.sv
// rtl/acf_accumulator_if.sv - sample input / autocorrelation output bus for acf_accumulator
interface acf_accumulator_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 43
);
    logic signed [SAMPLE_WIDTH-1:0] iSample;
    logic                           iValid;
    logic                           iLast;
    logic                           oReady;
    logic signed [ACC_WIDTH-1:0]    oACF;
    logic [3:0]                     oLag;
    logic                           oValid;

    modport master (
        output iSample, iValid, iLast,
        input  oReady, oACF, oLag, oValid
    );

    modport slave (
        input  iSample, iValid, iLast,
        output oReady, oACF, oLag, oValid
    );
endinterface

// File: rtl/acf_accumulator.sv
// rtl/acf_accumulator.sv - block autocorrelation R[0..ORDER] accumulator with serial lag output
module acf_accumulator #(
    parameter int ORDER        = 12,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BLOCK_SIZE   = 4096,
    parameter int ACC_WIDTH    = 43
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iEnable,
    acf_accumulator_if.slave bus
);
    localparam int PW = 2 * SAMPLE_WIDTH;
    localparam int CW = $clog2(BLOCK_SIZE) + 1;
    localparam int LW = 4;

    typedef enum logic [1:0] {ACCUM, FLUSH, EMIT} state_t;

    state_t                         state_q, state_d;
    logic signed [SAMPLE_WIDTH-1:0] hist_q [1:ORDER];
    logic signed [SAMPLE_WIDTH-1:0] hist_d [1:ORDER];
    logic signed [PW-1:0]           prod_q [0:ORDER];
    logic signed [PW-1:0]           prod_d [0:ORDER];
    logic signed [ACC_WIDTH-1:0]    acc_q  [0:ORDER];
    logic signed [ACC_WIDTH-1:0]    acc_d  [0:ORDER];
    logic                           pvalid_q, pvalid_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           phase_q, phase_d;
    logic [LW-1:0]                  lag_q, lag_d;
    logic signed [ACC_WIDTH-1:0]    acf_q, acf_d;
    logic [LW-1:0]                  olag_q, olag_d;
    logic                           ovalid_q, ovalid_d;

    logic                           accept;
    logic signed [PW-1:0]           x_ext;

    assign accept     = bus.iValid && (state_q == ACCUM);
    assign x_ext      = PW'(bus.iSample);
    assign bus.oReady = (state_q == ACCUM);
    assign bus.oACF   = acf_q;
    assign bus.oLag   = olag_q;
    assign bus.oValid = ovalid_q;

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_q  <= ACCUM;
            pvalid_q <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            lag_q    <= '0;
            acf_q    <= '0;
            olag_q   <= '0;
            ovalid_q <= 1'b0;
            for (int k = 1; k <= ORDER; k++) hist_q[k] <= '0;
            for (int k = 0; k <= ORDER; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else if (iEnable) begin
            state_q  <= state_d;
            pvalid_q <= pvalid_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            lag_q    <= lag_d;
            acf_q    <= acf_d;
            olag_q   <= olag_d;
            ovalid_q <= ovalid_d;
            hist_q   <= hist_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        pvalid_d = accept;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        lag_d    = lag_q;
        acf_d    = acf_q;
        olag_d   = olag_q;
        ovalid_d = ovalid_q;

        // Stage 2 runs before the state case so the end-of-emit clear takes priority.
        if (pvalid_q) begin
            for (int k = 0; k <= ORDER; k++) acc_d[k] = acc_q[k] + ACC_WIDTH'(prod_q[k]);
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    prod_d[0] = x_ext * x_ext;
                    for (int k = 1; k <= ORDER; k++) prod_d[k] = x_ext * PW'(hist_q[k]);
                    hist_d[1] = bus.iSample;
                    for (int k = 2; k <= ORDER; k++) hist_d[k] = hist_q[k-1];
                    cnt_d = cnt_q + 1'b1;
                    if (bus.iLast || (cnt_q == CW'(BLOCK_SIZE - 1))) begin
                        state_d = FLUSH;
                        phase_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                phase_d = 1'b1;
                if (phase_q) begin
                    state_d = EMIT;
                    lag_d   = '0;
                end
            end
            EMIT: begin
                if (lag_q <= LW'(ORDER)) begin
                    ovalid_d = 1'b1;
                    olag_d   = lag_q;
                    acf_d    = acc_q[lag_q];
                    lag_d    = lag_q + 1'b1;
                end else begin
                    ovalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ACCUM;
                    for (int k = 1; k <= ORDER; k++) hist_d[k] = '0;
                    for (int k = 0; k <= ORDER; k++) acc_d[k] = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end
endmodule
